// File: rtl/mem_responder.sv
// mem_responder: loader-fed program memory with a CPU-facing RAM port.
//
// Operation: after reset the block sits in LOAD and accepts program words from
// the loader stream into consecutive RAM addresses. Loading ends on the word
// marked ld_last, or when the RAM is full. The block then holds the CPU in
// reset for HOLD_CYCLES cycles (RELEASE) and finally lets it run (RUN). In RUN
// the CPU reads and writes the RAM, and address 8'hFF maps to the io_out
// register. A reload pulse in RUN returns to LOAD without clearing the RAM or
// io_out.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_addr/w_en/w_data  CPU word address, write strobe and write data
//   cpu_r_data            registered read data, 1-cycle latency, 0 outside RUN
//   ld_valid/data/last    loader stream; ld_ready is high in LOAD
//   reload                return from RUN to LOAD
//   cpu_rst_n, run        CPU reset (low until RUN), RUN-state indicator
//   io_out                memory-mapped output register at 8'hFF
//   load_trunc            sticky: the last load filled the RAM without ld_last

module mem_responder #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cpu_addr,
  input  logic        cpu_w_en,
  input  logic [15:0] cpu_w_data,
  output logic [15:0] cpu_r_data,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic        reload,
  output logic        cpu_rst_n,
  output logic        run,
  output logic [15:0] io_out,
  output logic        load_trunc
);

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 255;
  localparam int unsigned CW    = 4;

  localparam logic [AW-1:0] IO_ADDR   = 8'hFF;
  localparam logic [AW-1:0] LAST_ADDR = 8'hFE;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   rel_cnt_q, rel_cnt_d;
  logic            trunc_q, trunc_d;
  logic [DW-1:0]   io_out_q, io_out_d;
  logic [DW-1:0]   r_data_q, r_data_d;
  logic            ld_ready_q;
  logic            cpu_rst_n_q;
  logic            run_q;

  logic [DW-1:0]   mem_q [DEPTH];
  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;
  logic            ld_xfer;

  // Asynchronous RAM read; only consulted for addresses below IO_ADDR.
  assign ram_rdata = mem_q[cpu_addr];

  // A loader handshake only counts once ld_ready is actually presented.
  assign ld_xfer = (state_q == ST_LOAD) && ld_valid && ld_ready_q;

  // Next-state, RAM write port and read-data selection.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rel_cnt_d = rel_cnt_q;
    trunc_d   = trunc_q;
    io_out_d  = io_out_q;
    r_data_d  = '0;
    ram_we    = 1'b0;
    ram_waddr = wcnt_q;
    ram_wdata = ld_data;

    case (state_q)
      ST_LOAD: begin
        if (ld_xfer) begin
          ram_we = 1'b1;
          wcnt_d = wcnt_q + AW'(1);
          if (ld_last) begin
            state_d   = ST_RELEASE;
            trunc_d   = 1'b0;
            rel_cnt_d = '0;
          end else if (wcnt_q == LAST_ADDR) begin
            // RAM is full: stop rather than wrap onto the program start.
            state_d   = ST_RELEASE;
            trunc_d   = 1'b1;
            rel_cnt_d = '0;
          end
        end
      end

      ST_RELEASE: begin
        if (rel_cnt_q == HOLD_LAST) begin
          state_d   = ST_RUN;
          rel_cnt_d = '0;
        end else begin
          rel_cnt_d = rel_cnt_q + CW'(1);
        end
      end

      ST_RUN: begin
        if (reload) begin
          state_d = ST_LOAD;
          wcnt_d  = '0;
        end else begin
          if (cpu_w_en) begin
            if (cpu_addr == IO_ADDR) begin
              io_out_d = cpu_w_data;
            end else begin
              ram_we    = 1'b1;
              ram_waddr = cpu_addr;
              ram_wdata = cpu_w_data;
            end
          end
          // Sources are pre-edge values, so a same-address write reads old data.
          r_data_d = (cpu_addr == IO_ADDR) ? io_out_q : ram_rdata;
        end
      end

      default: begin
        state_d = ST_LOAD;
        wcnt_d  = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      wcnt_q      <= '0;
      rel_cnt_q   <= '0;
      trunc_q     <= 1'b0;
      io_out_q    <= '0;
      r_data_q    <= '0;
      ld_ready_q  <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rel_cnt_q   <= rel_cnt_d;
      trunc_q     <= trunc_d;
      io_out_q    <= io_out_d;
      r_data_q    <= r_data_d;
      ld_ready_q  <= (state_d == ST_LOAD);
      cpu_rst_n_q <= (state_d == ST_RUN);
      run_q       <= (state_d == ST_RUN);
    end
  end

  // Program RAM; contents survive reset and reload.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_waddr] <= ram_wdata;
    end
  end

  assign cpu_r_data = r_data_q;
  assign ld_ready   = ld_ready_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign run        = run_q;
  assign io_out     = io_out_q;
  assign load_trunc = trunc_q;

endmodule
